regfile_wb_scheduler: RTL

- Shares the register file's single write port among NUM_SRC write-back sources (ALU, LSU, MUL/FPU).
- Tracks outstanding destination registers in a scoreboard so issue stalls on WAW hazards, and exports the busy vector for RAW hazard checks.
- Sits between the execute units and the register file. It drives reg_wren / write_address / write_data directly.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 31 +++
 rtl/regfile_wb_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Widths and shared types for the register-file write-back path.
// Pure declarations; no logic, no latency, no flow control.
package regfile_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2**REG_ADDR_W;

   typedef enum logic [1:0] {
      WB_SRC_ALU    = 2'd0,
      WB_SRC_LSU    = 2'd1,
      WB_SRC_MULFPU = 2'd2
   } wb_src_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin pick among requesters, searching upward from ptr with wrap.
// Purely combinational; zero latency, no internal backpressure.
module rr_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_grant
);

   int cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      cand      = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = (int'(ptr) + k) % NUM_SRC;
         if (!any_grant && req[cand]) begin
            any_grant   = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port among NUM_SRC one-deep result slots and keeps the busy scoreboard.
// Handshake to reg_wren is 2 cycles; a FULL slot drops src_ready until granted, issue stalls on busy[issue_rd].
module regfile_wb_scheduler #(
   parameter int NUM_SRC    = 3,
   parameter int XLEN       = regfile_pkg::XLEN,
   parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           issue_valid,
   input  logic [REG_ADDR_W-1:0]          issue_rd,
   output logic                           issue_ready,
   input  logic [NUM_SRC-1:0]             src_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]  src_rd,
   input  logic [NUM_SRC*XLEN-1:0]        src_data,
   output logic [NUM_SRC-1:0]             src_ready,
   output logic                           reg_wren,
   output logic [REG_ADDR_W-1:0]          write_address,
   output logic [XLEN-1:0]                write_data,
   output logic [2**REG_ADDR_W-1:0]       busy,
   output logic                           wb_err
);

   import regfile_pkg::slot_state_e;
   import regfile_pkg::SLOT_EMPTY;
   import regfile_pkg::SLOT_FULL;

   localparam int NUM_REGS = 2**REG_ADDR_W;
   localparam int IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   slot_state_e             slot_state     [NUM_SRC];
   slot_state_e             slot_state_nxt [NUM_SRC];
   logic [REG_ADDR_W-1:0]   slot_rd        [NUM_SRC];
   logic [XLEN-1:0]         slot_data      [NUM_SRC];
   logic [NUM_SRC-1:0]      slot_full;
   logic [NUM_SRC-1:0]      accept;
   logic [NUM_SRC-1:0]      grant;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        grant_idx;
   logic                    any_grant;
   logic [REG_ADDR_W-1:0]   gnt_rd;
   logic [XLEN-1:0]         gnt_data;
   logic                    gnt_write;
   logic                    issue_fire;
   logic [NUM_REGS-1:0]     busy_nxt;

   // Kept apart from the next-state logic so grant does not loop back through one block.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         slot_full[i] = (slot_state[i] == SLOT_FULL);
         src_ready[i] = (slot_state[i] == SLOT_EMPTY);
         accept[i]    = src_valid[i] && src_ready[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         slot_state_nxt[i] = slot_state[i];
         case (slot_state[i])
            SLOT_EMPTY: if (accept[i]) slot_state_nxt[i] = SLOT_FULL;
            SLOT_FULL:  if (grant[i])  slot_state_nxt[i] = SLOT_EMPTY;
            default:                   slot_state_nxt[i] = SLOT_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SRC; i++) slot_state[i] <= SLOT_EMPTY;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) slot_state[i] <= slot_state_nxt[i];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (accept[i]) begin
            slot_rd[i]   <= src_rd[i*REG_ADDR_W +: REG_ADDR_W];
            slot_data[i] <= src_data[i*XLEN +: XLEN];
         end
      end
   end

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req       (slot_full),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // x0 grants still drain their slot but never touch the write port or scoreboard.
   always_comb begin
      gnt_rd      = slot_rd[grant_idx];
      gnt_data    = slot_data[grant_idx];
      gnt_write   = any_grant && (gnt_rd != '0);
      issue_ready = !busy[issue_rd] || (issue_rd == '0);
      issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
      busy_nxt    = busy;
      if (gnt_write)  busy_nxt[gnt_rd]   = 1'b0;
      if (issue_fire) busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr        <= '0;
         busy          <= '0;
         reg_wren      <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         wb_err        <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         reg_wren <= gnt_write;
         if (gnt_write) begin
            write_address <= gnt_rd;
            write_data    <= gnt_data;
            if (!busy[gnt_rd]) wb_err <= 1'b1;
         end
         if (any_grant)
            rr_ptr <= (grant_idx == IDX_W'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule
